// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop synchronizer for one asynchronous input, with selectable reset level
module sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= {N{RST_VAL}};
    else ff <= {ff[N-2:0], d};
  assign q = ff[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, one-cycle valid / framing-error strobes
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxData,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  state_t        state;
  logic [CW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rxs;
  sync_bit #(.N(SYNC_STAGES), .RST_VAL(IDLE_LEVEL)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(rxData), .q(rxs)
  );
  assign rx_busy = (state != IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          baud <= '0;
          if (rxs != IDLE_LEVEL) state <= START;
        end
        // half-bit wait lands every later sample in the middle of its bit
        START:
          if (baud == HALF_LAST) begin
            baud    <= '0;
            bit_cnt <= '0;
            state   <= (rxs == IDLE_LEVEL) ? IDLE : DATA;
          end else baud <= baud + CW'(1);
        DATA:
          if (baud == BIT_LAST) begin
            baud  <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end else baud <= baud + CW'(1);
        STOP:
          if (baud == BIT_LAST) begin
            baud <= '0;
            if (rxs == IDLE_LEVEL) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RECOVER;
            end
          end else baud <= baud + CW'(1);
        // a held-low line must return high before a new start is accepted
        RECOVER: if (rxs == IDLE_LEVEL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err, rx_busy;
  int vectors = 0, miscompares = 0;
  int cyc = 0, valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  int vcyc [64];
  logic [7:0] vbyte [64];
  int t0, v0, e0;
  logic saw, fell;

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rxData(rx_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rx_valid && valid_cnt < 64) begin
      vcyc[valid_cnt]  = cyc;
      vbyte[valid_cnt] = rx_byte;
    end
    if (rx_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bit k spans floor(k*p10/10)..floor((k+1)*p10/10) cycles, p10 = tenths of a clock per bit
  task automatic send(input logic [7:0] b, input logic stop, input int p10);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_data = f[k];
      repeat (((k + 1) * p10) / 10 - (k * p10) / 10) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_byte", 32'(rx_byte), 32'h00);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    t0 = cyc;
    send(8'hA5, 1'b1, 160);
    repeat (10) @(negedge clk);
    check("clean_count", 32'(valid_cnt), 32'd1);
    check("clean_byte", 32'(vbyte[0]), 32'hA5);
    check("clean_latency", 32'((vcyc[0] - t0) >= 154 && (vcyc[0] - t0) <= 156), 32'd1);
    check("clean_ferr", 32'(err_cnt), 32'd0);

    send(8'h00, 1'b1, 160);
    send(8'hFF, 1'b1, 160);
    send(8'h3C, 1'b1, 160);
    repeat (10) @(negedge clk);
    check("b2b_count", 32'(valid_cnt), 32'd4);
    check("b2b_byte0", 32'(vbyte[1]), 32'h00);
    check("b2b_byte1", 32'(vbyte[2]), 32'hFF);
    check("b2b_byte2", 32'(vbyte[3]), 32'h3C);
    check("b2b_gap01", 32'(vcyc[2] - vcyc[1]), 32'd160);
    check("b2b_gap12", 32'(vcyc[3] - vcyc[2]), 32'd160);

    saw = 1'b0;
    fell = 1'b0;
    rx_data = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) rx_data = 1'b1;
      @(negedge clk);
      if (rx_busy) saw = 1'b1;
      if (saw && !rx_busy) fell = 1'b1;
    end
    repeat (20) @(negedge clk);
    check("glitch_busy_rose", 32'(saw), 32'd1);
    check("glitch_busy_fell", 32'(fell), 32'd1);
    check("glitch_no_valid", 32'(valid_cnt), 32'd4);
    check("glitch_no_ferr", 32'(err_cnt), 32'd0);

    send(8'h55, 1'b0, 160);
    repeat (40) @(negedge clk);
    check("ferr_count", 32'(err_cnt), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt), 32'd4);
    check("ferr_byte_held", 32'(rx_byte), 32'h3C);
    check("ferr_recover_busy", 32'(rx_busy), 32'd1);
    rx_data = 1'b1;
    repeat (6) @(negedge clk);
    check("ferr_recover_exit", 32'(rx_busy), 32'd0);
    send(8'h81, 1'b1, 160);
    repeat (10) @(negedge clk);
    check("after_ferr_count", 32'(valid_cnt), 32'd5);
    check("after_ferr_byte", 32'(rx_byte), 32'h81);

    v0 = valid_cnt;
    e0 = err_cnt;
    rx_data = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx_data = k < 2;
      repeat (16) @(negedge clk);
    end
    rx_data = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_busy_before", 32'(rx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_byte", 32'(rx_byte), 32'h00);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    rx_data = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("midrst_no_valid", 32'(valid_cnt), 32'(v0));
    check("midrst_no_ferr", 32'(err_cnt), 32'(e0));
    send(8'h7E, 1'b1, 160);
    repeat (10) @(negedge clk);
    check("midrst_next_count", 32'(valid_cnt), 32'(v0 + 1));
    check("midrst_next_byte", 32'(rx_byte), 32'h7E);

    send(8'h96, 1'b1, 154);
    repeat (20) @(negedge clk);
    check("skew_fast_count", 32'(valid_cnt), 32'(v0 + 2));
    check("skew_fast_byte", 32'(rx_byte), 32'h96);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h96, 1'b1, 166);
    repeat (20) @(negedge clk);
    check("skew_slow_count", 32'(valid_cnt), 32'(v0 + 3));
    check("skew_slow_byte", 32'(rx_byte), 32'h96);
    check("skew_no_ferr", 32'(err_cnt), 32'(e0));
    check("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the `rxData` pin: 8N1 frames, LSB first, line idles high.
- Recovers each frame and hands the byte to `MainModule`'s command logic as a one-cycle `rx_valid` strobe with `rx_byte`.
- Sits directly upstream of the command handling in `MainModule`.
- Flags malformed frames with `frame_err` and never delivers partial data.

Parameters:
- `CLKS_PER_BIT`, default 10416: clk cycles per bit (100 MHz / 9600 baud). Must be ≥ 8. The bench uses 16.
- `SYNC_STAGES`, default 2: metastability flops on `rxData`. Must be ≥ 2.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rxData`  in  1: raw asynchronous serial input.
- `rx_byte`  out  8: last correctly received byte; held until the next good frame.
- `rx_valid`  out  1: one-cycle pulse; `rx_byte` is valid in that cycle.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.
- `rx_busy`  out  1: high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, `rst_n`.
- Reset values:
  - Synchronizer flops = 1 (idle line), so there is no false start after reset.
  - `rx_byte` = 0x00; `rx_valid`, `frame_err`, `rx_busy` = 0.
  - FSM = IDLE; bit counter = 0; baud counter = 0.
- Synchronization: `rxData` passes through `SYNC_STAGES` flops. All logic sees only the synchronized bit `rxs`.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. "Wait N" means the counter runs 0..N-1, samples `rxs` on the cycle it equals N-1, then clears.
- FSM states:
  - IDLE: when `rxs` = 0, go to START; clear baud counter.
  - START: wait `CLKS_PER_BIT/2` (integer divide), then sample.
    - Sample 0: go to DATA, bit counter = 0.
    - Sample 1: glitch; go to IDLE with no outputs.
  - DATA: wait `CLKS_PER_BIT`, then shift the sample in. Shift right, with the new bit entering bit 7, so the first bit ends up as LSB.
    - After the 8th sample (bit counter = 7), go to STOP. Otherwise increment the bit counter.
  - STOP: wait `CLKS_PER_BIT`, then sample.
    - Sample 1: `rx_byte` <= shift register; pulse `rx_valid` the next cycle; go to IDLE.
    - Sample 0: pulse `frame_err`; `rx_byte` unchanged; go to RECOVER.
  - RECOVER (break or misaligned line): stay until `rxs` = 1, then go to IDLE. Prevents re-triggering on a held-low line.
- Output registers: `rx_valid` and `frame_err` are registered and never high together. Each is high for exactly one cycle per frame.
- Latency: from the `rxData` falling edge to `rx_valid` high is `SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1` cycles, ±1 cycle.
  - With defaults 2/16: 2 + 8 + 144 + 1 = 155.
- Back-to-back frames: a start bit arriving on the cycle after `rx_valid` is captured. IDLE reacts the first cycle `rxs` = 0; no gap is required beyond the stop bit.
- Mid-frame reset: asserting `rst_n` low aborts the frame immediately.
  - All state returns to reset values; no `rx_valid` or `frame_err` is produced.
  - After release, a line held low is treated as a start only after `rxs` has gone 1 → 0 through the synchronizer. Synchronizer flops reset to 1, so a held-low line produces one START that fails or resolves normally.
- No handshake back-pressure: the consumer must take `rx_byte` on `rx_valid`. An unread byte is overwritten only by the next good frame.
- Baud tolerance: sampling is at mid-bit, so ±4% clock mismatch must decode correctly.

Decomposition:
- Shared package `uart_pkg`:
  - State enum {IDLE, START, DATA, STOP, RECOVER}.
  - Localparams `DATA_BITS` = 8, `IDLE_LEVEL` = 1.
- One natural sub-module: `sync_bit` (N-flop synchronizer with a reset value parameter). It is reusable for `shaftPulseL`/`shaftPulseR` and the push buttons.
- The FSM and counters stay in `uart_rx`.

Test Plan:
- Clean frame: send 0xA5 with `CLKS_PER_BIT` = 16 → exactly one `rx_valid` pulse, `rx_byte` = 0xA5, at 155 ±1 cycles after the falling edge; `frame_err` stays 0.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap → three `rx_valid` pulses, bytes in order, spaced 160 cycles apart.
- Glitch rejection: drive `rxData` low for 3 cycles, then high → `rx_busy` rises then falls within 12 cycles; no `rx_valid` and no `frame_err`.
- Framing error: send 0x55 with the stop bit low, then hold low for 40 cycles, then high → one `frame_err` pulse; `rx_byte` keeps its previous value (0x3C); FSM stays in RECOVER until the line goes high; a subsequent 0x81 is received correctly.
- Mid-frame reset: pulse `rst_n` low for 2 cycles during data bit 4 of 0xC3 → all outputs return to 0 asynchronously; no spurious `rx_valid`; the next full frame 0x7E decodes correctly.
- Baud skew: transmit 0x96 at 15 and at 17 clocks per bit (about ±6%... use 15.4 and 16.6 averaged over the frame to stay within ±4%) → `rx_byte` = 0x96 in both cases, with no `frame_err`.
